// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan generator and layer compositor for a 640x480 @ 72 Hz display.
// Stage 0 holds the h/v counters that drive the coordinate bus, plus the combinational
// sync decode and the layer priority select. Stage 1 registers RGB and sync so that
// they reach the pins together, one clock after the coordinates.
module vga_scan_gen #(
    parameter int       H_ACTIVE   = 640,
    parameter int       H_FP       = 24,
    parameter int       H_SYNC     = 40,
    parameter int       H_BP       = 128,
    parameter int       V_ACTIVE   = 480,
    parameter int       V_FP       = 9,
    parameter int       V_SYNC     = 3,
    parameter int       V_BP       = 28,
    parameter logic     SYNC_POL   = 1'b0,
    parameter int       NUM_LAYERS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [11:0]               pixel_row,
    output logic [11:0]               pixel_column,
    output logic                      video_on,
    output logic                      frame_tick,
    input  logic [4*NUM_LAYERS-1:0]   layer_pix,
    input  logic [12*NUM_LAYERS-1:0]  layer_color,
    input  logic [11:0]               bg_color,
    output logic [11:0]               vga_rgb,
    output logic                      vga_hs,
    output logic                      vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All window edges are 12-bit unsigned so every compare matches the counter width.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        hs_active;
    logic        vs_active;
    logic [11:0] rgb_next;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Stage 0: pixel counter runs every clock; line counter steps only on the pixel wrap.
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Coordinates come straight from the counter registers; off-screen values pass through.
    assign pixel_column = h_cnt;
    assign pixel_row    = v_cnt;
    assign video_on     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_tick   = h_last && v_last;
    assign hs_active    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_active    = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Stage 0 composite: lowest-index opaque layer wins, background otherwise, black when blanked.
    // NOTE: rgb_next gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        rgb_next = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_pix[4*i +: 4] != 4'h0) begin
                rgb_next = layer_color[12*i +: 12];
            end
        end
        if (!video_on) begin
            rgb_next = 12'h000;
        end
    end

    // Stage 1: register colour and sync together so they stay aligned at the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_rgb <= 12'h000;
            vga_hs  <= ~SYNC_POL;
            vga_vs  <= ~SYNC_POL;
        end else begin
            vga_rgb <= rgb_next;
            vga_hs  <= hs_active ? SYNC_POL : ~SYNC_POL;
            vga_vs  <= vs_active ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
